// File: rtl/complex_div_seq.sv
// rtl/complex_div_seq.sv - sequential complex divider q = a*conj(b)/|b|^2 with fixed-point scaling
module complex_div_seq #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 12,
  parameter int OUT_W  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  a_q,
  input  logic signed [IN_W-1:0]  b_i,
  input  logic signed [IN_W-1:0]  b_q,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] p_i,
  output logic signed [OUT_W-1:0] p_q,
  output logic                    div_zero,
  output logic                    sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int P_W = 2*IN_W + 1;
  localparam int D_W = P_W + FRAC_W;
  localparam int C_W = $clog2(D_W);
  localparam int Q_W = ((D_W > OUT_W) ? D_W : OUT_W) + 1;
  localparam logic [Q_W-1:0] LIM = Q_W'(1) << (OUT_W-1);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;
  state_t state, state_next;

  logic signed [IN_W-1:0] ar, ai, br, bi;
  logic [D_W-1:0] dvd_r, dvd_i, quo_r, quo_i;
  logic [P_W-1:0] rem_r, rem_i, mag;
  logic           neg_r, neg_i;
  logic [C_W-1:0] count;

  function automatic logic signed [P_W-1:0] sx(input logic signed [IN_W-1:0] v);
    return {{(P_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  // Products are formed at P_W bits so the most-negative operands cannot overflow.
  logic signed [P_W-1:0] pr_c, pi_c, mag_c;
  logic [P_W-1:0] abs_r, abs_i;
  always_comb begin
    pr_c  = sx(ar)*sx(br) + sx(ai)*sx(bi);
    pi_c  = sx(ai)*sx(br) - sx(ar)*sx(bi);
    mag_c = sx(br)*sx(br) + sx(bi)*sx(bi);
    abs_r = pr_c[P_W-1] ? P_W'(-pr_c) : P_W'(pr_c);
    abs_i = pi_c[P_W-1] ? P_W'(-pi_c) : P_W'(pi_c);
  end

  // One restoring step per cycle; remainder always stays below mag so P_W bits suffice.
  logic [P_W:0] trial_r, trial_i, diff_r, diff_i;
  logic         ge_r, ge_i;
  always_comb begin
    trial_r = {rem_r, dvd_r[D_W-1]};
    trial_i = {rem_i, dvd_i[D_W-1]};
    diff_r  = trial_r - {1'b0, mag};
    diff_i  = trial_i - {1'b0, mag};
    ge_r    = trial_r >= {1'b0, mag};
    ge_i    = trial_i >= {1'b0, mag};
  end

  function automatic logic [OUT_W:0] fix(input logic [D_W-1:0] q, input logic neg);
    logic [Q_W-1:0] qx, sv;
    qx = Q_W'(q);
    sv = neg ? (~qx + 1'b1) : qx;
    if (!neg && qx >= LIM)
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (neg && qx > LIM)
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, sv[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] fix_r, fix_i;
  always_comb begin
    fix_r = fix(quo_r, neg_r);
    fix_i = fix(quo_i, neg_i);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = enable & ~reset & (state == S_IDLE);
    if (enable) begin
      case (state)
        S_IDLE: if (in_valid) state_next = S_MULT;
        S_MULT: state_next = S_DIV;
        S_DIV:  if (count == '0) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ar <= '0; ai <= '0; br <= '0; bi <= '0;
      dvd_r <= '0; dvd_i <= '0; quo_r <= '0; quo_i <= '0;
      rem_r <= '0; rem_i <= '0; mag <= '0;
      neg_r <= 1'b0; neg_i <= 1'b0; count <= '0;
      p_i <= '0; p_q <= '0; div_zero <= 1'b0; sat <= 1'b0; out_valid <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: if (in_valid) begin
          ar <= a_i; ai <= a_q; br <= b_i; bi <= b_q;
        end
        S_MULT: begin
          dvd_r <= {abs_r, {FRAC_W{1'b0}}};
          dvd_i <= {abs_i, {FRAC_W{1'b0}}};
          mag   <= P_W'(mag_c);
          neg_r <= pr_c[P_W-1];
          neg_i <= pi_c[P_W-1];
          rem_r <= '0; rem_i <= '0; quo_r <= '0; quo_i <= '0;
          count <= C_W'(D_W-1);
        end
        S_DIV: begin
          dvd_r <= dvd_r << 1;
          dvd_i <= dvd_i << 1;
          rem_r <= ge_r ? diff_r[P_W-1:0] : trial_r[P_W-1:0];
          rem_i <= ge_i ? diff_i[P_W-1:0] : trial_i[P_W-1:0];
          quo_r <= {quo_r[D_W-2:0], ge_r};
          quo_i <= {quo_i[D_W-2:0], ge_i};
          count <= count - 1'b1;
        end
        S_FIX: begin
          // A zero divisor still runs the full divide; its all-ones quotient is discarded here.
          if (mag == '0) begin
            p_i <= '0; p_q <= '0; div_zero <= 1'b1; sat <= 1'b0;
          end else begin
            p_i <= fix_r[OUT_W-1:0];
            p_q <= fix_i[OUT_W-1:0];
            div_zero <= 1'b0;
            sat <= fix_r[OUT_W] | fix_i[OUT_W];
          end
          out_valid <= 1'b1;
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div_seq.sv
// tb/tb_complex_div_seq.sv - directed self-checking bench for complex_div_seq
module tb_complex_div_seq;
  logic clock = 1'b0;
  logic reset, enable, in_valid, out_ready;
  logic signed [15:0] a_i, a_q, b_i, b_q;
  logic in_ready, div_zero, sat, out_valid;
  logic in_ready16, div_zero16, sat16, out_valid16;
  logic signed [31:0] p_i, p_q;
  logic signed [15:0] p16_i, p16_q;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int seen;

  always #5 clock = ~clock;

  complex_div_seq u_dut (
    .clock(clock), .reset(reset), .enable(enable),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
    .in_valid(in_valid), .in_ready(in_ready),
    .p_i(p_i), .p_q(p_q), .div_zero(div_zero), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  complex_div_seq #(.OUT_W(16)) u_dut16 (
    .clock(clock), .reset(reset), .enable(enable),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
    .in_valid(in_valid), .in_ready(in_ready16),
    .p_i(p16_i), .p_q(p16_q), .div_zero(div_zero16), .sat(sat16),
    .out_valid(out_valid16), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic signed [15:0] xi, xq, yi, yq);
    a_i = xi; a_q = xq; b_i = yi; b_q = yq;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    a_i = 16'sh5a5a; a_q = -16'sh1234; b_i = 16'sh0f0f; b_q = 16'sh7777;
    cyc = 1;
  endtask

  task automatic wait_out();
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic op(input string tag, input logic signed [15:0] xi, xq, yi, yq,
                    input logic signed [31:0] ei, eq, input logic ez);
    start(xi, xq, yi, yq);
    wait_out();
    check({tag, "_lat"}, cyc, 48);
    check({tag, "_p_i"}, p_i, ei);
    check({tag, "_p_q"}, p_q, eq);
    check({tag, "_div_zero"}, div_zero, ez);
    check({tag, "_sat"}, sat, 0);
  endtask

  task automatic release_out();
    step();
    check("handshake_out_valid", out_valid, 0);
    check("handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; a_q = '0; b_i = '0; b_q = '0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_p_i", p_i, 0);
    check("rst_p_q", p_q, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_sat", sat, 0);
    reset = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);

    op("unit", 100, 0, 100, 0, 4096, 0, 0);
    release_out();
    op("trunc", 3, 4, 1, 2, 9011, -1638, 0);
    release_out();
    op("imag_over_imag", 0, 100, 0, 100, 4096, 0, 0);
    release_out();
    op("real_over_imag", 100, 0, 0, 100, 0, -4096, 0);
    release_out();
    op("div_zero", 5, -7, 0, 0, 0, 0, 1);
    check("div_zero16", div_zero16, 1);
    check("div_zero_sat16", sat16, 0);
    release_out();

    op("pos_big", 32767, 0, 1, 0, 134213632, 0, 0);
    check("sat16_pos_p_i", p16_i, 32767);
    check("sat16_pos_p_q", p16_q, 0);
    check("sat16_pos_flag", sat16, 1);
    release_out();
    op("neg_big", -32768, 0, 1, 0, -134217728, 0, 0);
    check("sat16_neg_p_i", p16_i, -32768);
    check("sat16_neg_flag", sat16, 1);
    release_out();
    op("most_neg", -32768, -32768, -32768, -32768, 4096, 0, 0);
    check("most_neg16_p_i", p16_i, 4096);
    check("most_neg16_p_q", p16_q, 0);
    check("most_neg16_sat", sat16, 0);
    release_out();

    // Backpressure: result must hold while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    op("stall", 3, 4, 1, 2, 9011, -1638, 0);
    a_i = 1; a_q = 1; b_i = 1; b_q = 1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_out_valid", out_valid, 1);
      check("stall_p_i", p_i, 9011);
      check("stall_p_q", p_q, -1638);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    enable = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("en_low_hold_valid", out_valid, 1);
    check("en_low_in_ready", in_ready, 0);
    enable = 1'b1;
    release_out();

    start(100, 0, 100, 0);
    repeat (10) begin step(); cyc++; end
    enable = 1'b0;
    repeat (5) begin step(); cyc++; end
    enable = 1'b1;
    wait_out();
    check("enable_gap_lat", cyc, 53);
    check("enable_gap_p_i", p_i, 4096);
    release_out();

    start(100, 0, 100, 0);
    repeat (20) step();
    reset = 1'b1;
    step();
    check("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    step();
    check("mid_rst_release_in_ready", in_ready, 1);
    check("mid_rst_p_i", p_i, 0);
    seen = 0;
    repeat (60) begin
      step();
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_output", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
